master_ctrl: RTL and testbench

MASTER_CTRL -- requirements
Module: master

---
 rtl/master_ctrl.sv | 164 ++++++++++++++++
 tb/tb_master_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/master_ctrl.sv
// master_ctrl: serial bus master that arbitrates for the bus, shifts out a
// 16-bit address MSB first, then either shifts out 8 write-data bits or
// samples 8 read-data bits, with slave acknowledge handshakes in between.
//   CLK        clock, rising edge
//   RSTN       asynchronous reset, active HIGH despite the name
//   M_DIN      write data from the local device
//   M_ADDR     target address
//   M_RW       1 = write, 0 = read
//   M_EXECUTE  start transaction (level, must drop between transactions)
//   M_HOLD     device wants the bus
//   M_DOUT     read data, updated only on a completed read
//   M_DVALID   one-cycle completion pulse
//   M_BSY      transaction in progress
//   B_REQ      bus request to the arbiter
//   B_GRANT    arbiter grant; loss of grant mid-transaction aborts
//   B_UTIL     bus in use by this master
//   B_RW       latched transaction direction
//   B_ACK      slave acknowledge
//   B_BUS_OUT  serial address / write-data line
//   B_BUS_IN   serial read-data line
module master_ctrl (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [7:0]  M_DIN,
   input  logic [15:0] M_ADDR,
   input  logic        M_RW,
   input  logic        M_EXECUTE,
   input  logic        M_HOLD,
   output logic [7:0]  M_DOUT,
   output logic        M_DVALID,
   output logic        M_BSY,
   output logic        B_REQ,
   input  logic        B_GRANT,
   output logic        B_UTIL,
   output logic        B_RW,
   input  logic        B_ACK,
   output logic        B_BUS_OUT,
   input  logic        B_BUS_IN
);
   typedef enum logic [2:0] {IDLE, REQ, ADDR, ACK1, WDATA, ACK2, RDATA, DONE} state_t;
   state_t state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [14:0] addr_q, addr_n;
   logic [7:0]  din_q, din_n, dout_n;
   logic [6:0]  sh, sh_n;
   logic        rw_q, rw_n, phase, phase_n, started, started_n, bout_n, busy_n;
   // addr_q/din_q are shift registers: the bit on the line next cycle is
   // always their top bit. Address bit 15 goes straight from M_ADDR to the
   // line, so only 15 bits are kept. phase marks "ACK seen high" in ACK1
   // (read) and "ACK back low, data running" in WDATA. started blocks a
   // restart until M_EXECUTE has been low once.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      addr_n    = addr_q;
      din_n     = din_q;
      rw_n      = rw_q;
      phase_n   = phase;
      sh_n      = sh;
      started_n = started & M_EXECUTE;
      dout_n    = M_DOUT;
      bout_n    = 1'b0;
      case (state)
         IDLE: state_n = M_HOLD ? REQ : IDLE;
         REQ:
            if (!M_HOLD) state_n = IDLE;
            else if (B_GRANT && M_EXECUTE && !started) begin
               state_n   = ADDR;
               addr_n    = M_ADDR[14:0];
               din_n     = M_DIN;
               rw_n      = M_RW;
               started_n = 1'b1;
               cnt_n     = 4'd0;
               phase_n   = 1'b0;
               bout_n    = M_ADDR[15];
            end
         ADDR:
            if (cnt == 4'd15) state_n = ACK1;
            else begin
               cnt_n  = cnt + 4'd1;
               bout_n = addr_q[14];
               addr_n = {addr_q[13:0], 1'b0};
            end
         ACK1:
            if (!phase) begin
               if (B_ACK) begin
                  if (rw_q) state_n = WDATA;
                  else phase_n = 1'b1;
               end
            end else if (!B_ACK) begin
               state_n = RDATA;
               cnt_n   = 4'd0;
               sh_n    = {6'd0, B_BUS_IN};
            end
         WDATA:
            if (!phase) begin
               if (!B_ACK) begin
                  phase_n = 1'b1;
                  cnt_n   = 4'd0;
                  bout_n  = din_q[7];
               end
            end else if (cnt == 4'd7) state_n = ACK2;
            else begin
               cnt_n  = cnt + 4'd1;
               bout_n = din_q[6];
               din_n  = {din_q[6:0], 1'b0};
            end
         ACK2: state_n = B_ACK ? DONE : ACK2;
         RDATA: begin
            sh_n = {sh[5:0], B_BUS_IN};
            if (cnt == 4'd6) begin
               state_n = DONE;
               dout_n  = {sh, B_BUS_IN};
            end else cnt_n = cnt + 4'd1;
         end
         DONE: state_n = M_HOLD ? REQ : IDLE;
         default: state_n = IDLE;
      endcase
      // losing the grant while owning the bus abandons the transaction
      if (!B_GRANT && state inside {ADDR, ACK1, WDATA, ACK2, RDATA}) begin
         state_n = IDLE;
         bout_n  = 1'b0;
         dout_n  = M_DOUT;
      end
      busy_n = state_n inside {ADDR, ACK1, WDATA, ACK2, RDATA};
   end
   // outputs are registered from the next-state decode so they line up
   // with the state they describe
   always_ff @(posedge CLK or posedge RSTN) begin
      if (RSTN) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         addr_q    <= 15'd0;
         din_q     <= 8'd0;
         rw_q      <= 1'b0;
         phase     <= 1'b0;
         sh        <= 7'd0;
         started   <= 1'b0;
         M_DOUT    <= 8'd0;
         M_DVALID  <= 1'b0;
         M_BSY     <= 1'b0;
         B_REQ     <= 1'b0;
         B_UTIL    <= 1'b0;
         B_RW      <= 1'b0;
         B_BUS_OUT <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         addr_q    <= addr_n;
         din_q     <= din_n;
         rw_q      <= rw_n;
         phase     <= phase_n;
         sh        <= sh_n;
         started   <= started_n;
         M_DOUT    <= dout_n;
         M_DVALID  <= state_n == DONE;
         M_BSY     <= busy_n;
         B_REQ     <= state_n != IDLE;
         B_UTIL    <= busy_n;
         B_RW      <= busy_n & rw_n;
         B_BUS_OUT <= bout_n;
      end
   end
endmodule

// File: tb/tb_master_ctrl.sv
// tb_master_ctrl: directed bench for master_ctrl; transaction tasks derive the
// per-cycle expected bus behaviour from address/data values, and one compare
// process checks every output at each falling edge.
module tb_master_ctrl;
   logic        CLK = 1'b0, RSTN = 1'b1;
   logic [7:0]  M_DIN = 8'd0;
   logic [15:0] M_ADDR = 16'd0;
   logic        M_RW = 1'b0, M_EXECUTE = 1'b0, M_HOLD = 1'b0;
   logic        B_GRANT = 1'b0, B_ACK = 1'b0, B_BUS_IN = 1'b0;
   logic [7:0]  M_DOUT;
   logic        M_DVALID, M_BSY, B_REQ, B_UTIL, B_RW, B_BUS_OUT;
   master_ctrl dut (
      .CLK(CLK), .RSTN(RSTN), .M_DIN(M_DIN), .M_ADDR(M_ADDR), .M_RW(M_RW),
      .M_EXECUTE(M_EXECUTE), .M_HOLD(M_HOLD), .M_DOUT(M_DOUT), .M_DVALID(M_DVALID),
      .M_BSY(M_BSY), .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL), .B_RW(B_RW),
      .B_ACK(B_ACK), .B_BUS_OUT(B_BUS_OUT), .B_BUS_IN(B_BUS_IN)
   );
   always #5 CLK = ~CLK;
   int n_chk = 0, n_fail = 0, dv_cnt = 0;
   logic e_req = 0, e_busy = 0, e_rw = 0, e_out = 0, e_dv = 0, e_cap = 0, cur_rw = 0;
   logic [7:0]  e_dout = 8'd0;
   logic [23:0] cap = 24'd0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge CLK) begin
      check("B_REQ", B_REQ, e_req);
      check("B_UTIL", B_UTIL, e_busy);
      check("M_BSY", M_BSY, e_busy);
      check("B_RW", B_RW, e_rw);
      check("B_BUS_OUT", B_BUS_OUT, e_out);
      check("M_DVALID", M_DVALID, e_dv);
      check("M_DOUT", M_DOUT, e_dout);
      if (e_cap) cap = {cap[22:0], B_BUS_OUT};
      if (M_DVALID) dv_cnt++;
   end
   // one clock edge, then the outputs expected for the cycle that follows
   task automatic step(input logic r, input logic b, input logic o, input logic v, input logic c);
      @(posedge CLK); #1;
      e_req = r; e_busy = b; e_rw = b & cur_rw; e_out = o; e_dv = v; e_cap = c;
   endtask
   // from REQ with grant: start and shift out the first n address bits
   task automatic start_addr(input logic [15:0] a, input logic rw, input logic [7:0] d, input int n);
      M_ADDR = a; M_DIN = d; M_RW = rw; M_EXECUTE = 1'b1; cur_rw = rw;
      for (int i = 15; i > 15 - n; i--) step(1, 1, a[i], 0, 1);
   endtask
   // after 16 address bits: ACK1 wait, ACK high for 2 cycles, then data, DONE
   task automatic finish_xfer(input logic [7:0] d, input int ackdly, input logic [7:0] rb);
      for (int j = 0; j <= ackdly; j++) step(1, 1, 0, 0, 0);
      B_ACK = 1'b1;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      B_ACK = 1'b0;
      if (cur_rw) begin
         for (int i = 7; i >= 0; i--) step(1, 1, d[i], 0, 1);
         step(1, 1, 0, 0, 0);
         B_ACK = 1'b1;
         step(1, 0, 0, 1, 0);
         B_ACK = 1'b0;
      end else begin
         for (int i = 7; i >= 1; i--) begin
            B_BUS_IN = rb[i];
            step(1, 1, 0, 0, 0);
         end
         B_BUS_IN = rb[0];
         step(1, 0, 0, 1, 0);
         e_dout = rb;
         B_BUS_IN = 1'b0;
      end
   endtask
   initial begin
      repeat (2) @(posedge CLK);
      #1 RSTN = 1'b0;
      step(0, 0, 0, 0, 0);
      M_HOLD = 1'b1; M_EXECUTE = 1'b1;
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
      B_GRANT = 1'b1;
      cap = 24'd0;
      start_addr(16'hA5C3, 1'b1, 8'hAD, 16);
      finish_xfer(8'hAD, 50, 8'h00);
      step(1, 0, 0, 0, 0);
      check("wr_serial", cap, 24'hA5C3AD);
      check("dv_after_wr", dv_cnt, 1);
      repeat (3) step(1, 0, 0, 0, 0);
      M_EXECUTE = 1'b0;
      step(1, 0, 0, 0, 0);
      start_addr(16'h1234, 1'b0, 8'h00, 16);
      finish_xfer(8'h00, 0, 8'hAD);
      step(1, 0, 0, 0, 0);
      check("rd_dout", M_DOUT, 8'hAD);
      check("dv_after_rd", dv_cnt, 2);
      M_EXECUTE = 1'b0;
      step(1, 0, 0, 0, 0);
      start_addr(16'hFFFF, 1'b1, 8'h5A, 5);
      B_GRANT = 1'b0;
      step(0, 0, 0, 0, 0);
      B_GRANT = 1'b1;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("dv_after_abort", dv_cnt, 2);
      check("dout_after_abort", M_DOUT, 8'hAD);
      M_EXECUTE = 1'b0;
      step(1, 0, 0, 0, 0);
      start_addr(16'h0F0F, 1'b1, 8'h3C, 16);
      M_HOLD = 1'b0;
      finish_xfer(8'h3C, 3, 8'h00);
      step(0, 0, 0, 0, 0);
      check("dv_after_hold_drop", dv_cnt, 3);
      M_HOLD = 1'b1; M_EXECUTE = 1'b0;
      step(1, 0, 0, 0, 0);
      start_addr(16'hA5C3, 1'b1, 8'hAD, 6);
      #2;
      e_req = 0; e_busy = 0; e_rw = 0; e_out = 0; e_dv = 0; e_cap = 0; e_dout = 8'd0;
      RSTN = 1'b1;
      #1;
      check("rst_util", B_UTIL, 0);
      check("rst_bsy", M_BSY, 0);
      check("rst_req", B_REQ, 0);
      check("rst_dout", M_DOUT, 8'h00);
      M_HOLD = 1'b0;
      step(0, 0, 0, 0, 0);
      RSTN = 1'b0;
      step(0, 0, 0, 0, 0);
      M_HOLD = 1'b1;
      step(1, 0, 0, 0, 0);
      check("dv_total", dv_cnt, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
